key_debounce: RTL and testbench

- Front-end conditioner for the board push-buttons. Converts a raw, bouncing, asynchronous key level into clean single-cycle event pulses.
- Sits directly upstream of the pulse-hold stretcher. `press_o` drives its trigger input `trick_i`.
- Provides optional auto-repeat while the key is held, so the board cursor can step continuously.
- One instance per physical button.

---
 rtl/key_debounce.sv | 74 +++++++
 tb/tb_key_debounce.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus debounce FSM producing press/release pulses,
// a debounced level, and optional auto-repeat while the key is held.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 15000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LEVEL    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o,
  output logic release_o,
  output logic key_level_o
);
  typedef enum logic [2:0] {IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT} state_e;
  localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] DLY_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PER_LAST = 32'(REPEAT_PERIOD - 1);
  logic [1:0] sync_q;
  logic key_s;
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic press_q, press_d, release_q, release_d, level_q, level_d;
  logic db_done, dly_done, per_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {2{!ACTIVE_LEVEL}};
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      level_q   <= level_d;
    end
  end
  assign key_s    = (sync_q[1] == ACTIVE_LEVEL);
  assign db_done  = (cnt_q == DB_LAST);
  assign dly_done = (cnt_q == DLY_LAST);
  assign per_done = (cnt_q == PER_LAST);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (key_s) state_d = PRESS_WAIT;
      PRESS_WAIT:   state_d = !key_s ? IDLE : db_done ? HELD : PRESS_WAIT;
      HELD:         state_d = !key_s ? RELEASE_WAIT : (REPEAT_EN && dly_done) ? REPEAT : HELD;
      REPEAT:       if (!key_s) state_d = RELEASE_WAIT;
      RELEASE_WAIT: state_d = key_s ? HELD : db_done ? IDLE : RELEASE_WAIT;
      default:      state_d = IDLE;
    endcase
    // HELD with auto-repeat off parks the counter at its terminal value
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0
          : (state_q == REPEAT && per_done)         ? '0
          : (state_q == HELD && dly_done)           ? cnt_q
          :                                           cnt_q + 32'd1;
  end
  always_comb begin
    press_d   = key_s && ((state_q == PRESS_WAIT && db_done) ||
                          (REPEAT_EN && state_q == HELD && dly_done) ||
                          (state_q == REPEAT && per_done));
    release_d = !key_s && state_q == RELEASE_WAIT && db_done;
    level_d   = state_d inside {HELD, REPEAT, RELEASE_WAIT};
  end
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign key_level_o = level_q;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: three instances (no repeat, repeat, active-low key) checked every
// cycle against a run-length/schedule model plus hand-computed timing pins.
module tb_key_debounce;
  localparam int D = 4, RD = 10, RP = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b0;
  logic key_n;
  logic pa, ra, la, pb, rb, lb, pc, rc, lc;
  int n_assert = 0, n_fail = 0;
  bit h1, h2, m_ks;
  int t;
  bit lvl [2];
  int run [2];
  int nrep [2];
  bit ep [2];
  bit er [2];
  always #5 clk = ~clk;
  assign key_n = ~key;
  key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                 .REPEAT_EN(1'b0), .ACTIVE_LEVEL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_i(key), .press_o(pa), .release_o(ra), .key_level_o(la));
  key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                 .REPEAT_EN(1'b1), .ACTIVE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_i(key), .press_o(pb), .release_o(rb), .key_level_o(lb));
  key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                 .REPEAT_EN(1'b0), .ACTIVE_LEVEL(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .key_i(key_n), .press_o(pc), .release_o(rc), .key_level_o(lc));

  task automatic chk(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: the level flips once the synced key has disagreed with it for D+1
  // consecutive samples; repeats are scheduled by absolute edge number.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      h1 = 1'b0; h2 = 1'b0;
      for (int m = 0; m < 2; m++) begin
        lvl[m] = 1'b0; run[m] = 0; ep[m] = 1'b0; er[m] = 1'b0;
      end
    end else begin
      m_ks = h2; h2 = h1; h1 = key; t++;
      for (int m = 0; m < 2; m++) begin
        ep[m] = 1'b0; er[m] = 1'b0;
        if (m_ks != lvl[m]) begin
          run[m]++;
          if (run[m] == D + 1) begin
            lvl[m] = m_ks; run[m] = 0;
            if (m_ks) begin ep[m] = 1'b1; nrep[m] = t + RD; end
            else er[m] = 1'b1;
          end
        end else begin
          if (run[m] != 0 && lvl[m]) nrep[m] = t + RD;
          run[m] = 0;
          if (lvl[m] && m == 1 && t == nrep[m]) begin ep[m] = 1'b1; nrep[m] = t + RP; end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_a_press", pa, ep[0]); chk("cmp_a_release", ra, er[0]); chk("cmp_a_level", la, lvl[0]);
    chk("cmp_b_press", pb, ep[1]); chk("cmp_b_release", rb, er[1]); chk("cmp_b_level", lb, lvl[1]);
    chk("cmp_c_press", pc, ep[0]); chk("cmp_c_release", rc, er[0]); chk("cmp_c_level", lc, lvl[0]);
  end

  initial begin
    int w;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("reset_a_level", la, 1'b0); chk("reset_b_press", pb, 1'b0); chk("reset_c_level", lc, 1'b0);
    // short glitches never reach the debounce threshold
    for (int g = 0; g < 10; g++) begin
      key = 1'b1; tick(3);
      key = 1'b0; tick(3);
    end
    chk("glitch_a_level", la, 1'b0); chk("glitch_b_level", lb, 1'b0); chk("glitch_c_level", lc, 1'b0);
    tick(5);
    key = 1'b1;
    tick(6);
    chk("s1_early_a_press", pa, 1'b0); chk("s1_early_a_level", la, 1'b0); chk("s1_early_c_press", pc, 1'b0);
    tick(1);
    chk("s1_a_press", pa, 1'b1); chk("s1_a_level", la, 1'b1);
    chk("s1_b_press", pb, 1'b1); chk("s1_c_press", pc, 1'b1); chk("s1_c_level", lc, 1'b1);
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      chk("s1_a_no_repeat", pa, 1'b0);
      chk("s3_b_repeat", pb, i >= RD && (i - RD) % RP == 0);
    end
    key = 1'b0; tick(2);
    key = 1'b1; tick(1);
    key = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("s4_b_no_release", rb, 1'b0); chk("s4_b_level_held", lb, 1'b1);
    end
    tick(1);
    chk("s4_b_release", rb, 1'b1); chk("s4_b_level_low", lb, 1'b0);
    chk("s4_a_release", ra, 1'b1); chk("s4_c_release", rc, 1'b1);
    tick(10);
    key = 1'b1;
    w = 0;
    do begin tick(1); w++; end while (!pb && w < 20);
    chk("s4b_press_seen", pb, 1'b1);
    chk("s4b_press_latency", w == D + 3, 1'b1);
    key = 1'b0; tick(1);
    key = 1'b1; tick(9);
    chk("s4b_no_early_repeat", pb, 1'b0);
    tick(3);
    chk("s4b_no_repeat_13", pb, 1'b0);
    chk("s4b_no_release", rb, 1'b0);
    tick(1);
    chk("s4b_restarted_repeat", pb, 1'b1);
    tick(3);
    chk("s4b_period_repeat", pb, 1'b1);
    tick(3);
    chk("s5_pre_reset_press", pb, 1'b1); chk("s5_pre_reset_level", lb, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_b_press", pb, 1'b0); chk("s5_async_b_level", lb, 1'b0);
    chk("s5_async_a_level", la, 1'b0); chk("s5_async_c_level", lc, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("s5_early_a_press", pa, 1'b0); chk("s5_early_b_press", pb, 1'b0); chk("s5_early_c_press", pc, 1'b0);
    tick(1);
    chk("s5_a_press", pa, 1'b1); chk("s5_b_press", pb, 1'b1); chk("s5_c_press", pc, 1'b1);
    chk("s5_a_level", la, 1'b1); chk("s5_c_level", lc, 1'b1);
    key = 1'b0;
    tick(12);
    chk("end_a_level", la, 1'b0); chk("end_c_level", lc, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
